// File: rtl/traffic_monitor_if.sv
// traffic_monitor_if: car/walker light bus as seen by the passive monitor, plus its report outputs.
// master = stimulus/controller side, slave = the monitor itself.
interface traffic_monitor_if;
    logic        i_clear;
    logic [3:0]  i_car_traffic;
    logic [1:0]  i_walker_traffic;
    logic [2:0]  o_phase;
    logic        o_err_code;
    logic        o_err_seq;
    logic        o_err_len;
    logic        o_err_conflict;
    logic        o_cycle_done;
    logic [15:0] o_cycle_count;

    modport master (
        output i_clear, i_car_traffic, i_walker_traffic,
        input  o_phase, o_err_code, o_err_seq, o_err_len, o_err_conflict, o_cycle_done, o_cycle_count
    );

    modport slave (
        input  i_clear, i_car_traffic, i_walker_traffic,
        output o_phase, o_err_code, o_err_seq, o_err_len, o_err_conflict, o_cycle_done, o_cycle_count
    );
endinterface

// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker of light codes, phase order, phase lengths and car/walker conflicts.
// Define TRAFFIC_MON_WALKER_CHECK_EN to also check the walker pattern during car RED.
module traffic_monitor #(
    parameter int GREEN_LEN  = 20,
    parameter int YELLOW_LEN = 2,
    parameter int LEFT_LEN   = 10,
    parameter int RED_LEN    = 34,
`ifdef TRAFFIC_MON_WALKER_CHECK_EN
    parameter int WGREEN_LEN = 14,
    parameter int BLINK_LEN  = 6,
`endif
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    traffic_monitor_if.slave mon
);
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_GREEN    = 3'd1,
        PH_YELLOW_A = 3'd2,
        PH_LEFT     = 3'd3,
        PH_YELLOW_B = 3'd4,
        PH_RED      = 3'd5
    } phase_e;

    localparam logic [3:0] CAR_NONE   = 4'b0000;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [1:0] WLK_NONE   = 2'b00;
    localparam logic [1:0] WLK_GREEN  = 2'b01;
    localparam logic [1:0] WLK_RED    = 2'b10;

    phase_e           state_q, state_d, target_s;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             aligned_q, aligned_d;
    logic             err_code_q, err_code_d, err_seq_q, err_seq_d;
    logic             err_len_q, err_len_d, err_conf_q, err_conf_d;
    logic             done_q, done_d;
    logic [15:0]      count_q, count_d;
    logic             code_ok_s, car_none_s, hold_s, step_ok_s, conflict_s, walk_err_s;

    function automatic logic [LEN_W-1:0] phase_len(input phase_e p);
        case (p)
            PH_GREEN:                 phase_len = LEN_W'(GREEN_LEN);
            PH_YELLOW_A, PH_YELLOW_B: phase_len = LEN_W'(YELLOW_LEN);
            PH_LEFT:                  phase_len = LEN_W'(LEFT_LEN);
            PH_RED:                   phase_len = LEN_W'(RED_LEN);
            default:                  phase_len = {LEN_W{1'b0}};
        endcase
    endfunction

    // Classify the sampled codes and resolve the phase the car code names
    always_comb begin
        code_ok_s  = 1'b0;
        conflict_s = 1'b0;
        target_s   = PH_IDLE;
        car_none_s = (mon.i_car_traffic == CAR_NONE);
        case (mon.i_car_traffic)
            CAR_NONE: begin
                code_ok_s = (mon.i_walker_traffic == WLK_NONE);
                target_s  = PH_IDLE;
            end
            CAR_GREEN: begin
                code_ok_s  = (mon.i_walker_traffic != 2'b11);
                conflict_s = (mon.i_walker_traffic != WLK_RED);
                target_s   = PH_GREEN;
            end
            CAR_YELLOW: begin
                code_ok_s  = (mon.i_walker_traffic != 2'b11);
                conflict_s = (mon.i_walker_traffic != WLK_RED);
                target_s   = (state_q == PH_GREEN || state_q == PH_YELLOW_A) ? PH_YELLOW_A : PH_YELLOW_B;
            end
            CAR_LEFT: begin
                code_ok_s  = (mon.i_walker_traffic != 2'b11);
                conflict_s = (mon.i_walker_traffic != WLK_RED);
                target_s   = PH_LEFT;
            end
            CAR_RED: begin
                code_ok_s = (mon.i_walker_traffic != 2'b11);
                target_s  = PH_RED;
            end
            default: begin
                code_ok_s = 1'b0;
                target_s  = PH_IDLE;
            end
        endcase
        hold_s    = (target_s == state_q);
        step_ok_s = (state_q == PH_GREEN    && target_s == PH_YELLOW_A) ||
                    (state_q == PH_YELLOW_A && target_s == PH_LEFT)     ||
                    (state_q == PH_LEFT     && target_s == PH_YELLOW_B) ||
                    (state_q == PH_YELLOW_B && target_s == PH_RED)      ||
                    (state_q == PH_RED      && target_s == PH_GREEN);
    end

    // Next phase, length counter, alignment and sticky error flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aligned_d  = aligned_q;
        err_code_d = err_code_q;
        err_seq_d  = err_seq_q;
        err_len_d  = err_len_q;
        err_conf_d = err_conf_q;
        done_d     = 1'b0;
        count_d    = count_q;
        if (mon.i_clear) begin
            state_d    = PH_IDLE;
            cnt_d      = {LEN_W{1'b0}};
            aligned_d  = 1'b0;
            err_code_d = 1'b0;
            err_seq_d  = 1'b0;
            err_len_d  = 1'b0;
            err_conf_d = 1'b0;
            count_d    = 16'd0;
        end else begin
            err_conf_d = err_conf_q | conflict_s;
            if (!code_ok_s) begin
                err_code_d = 1'b1;
            end else if (car_none_s) begin
                state_d   = PH_IDLE;
                cnt_d     = LEN_W'(1);
                aligned_d = 1'b0;
            end else if (hold_s) begin
                cnt_d     = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);
                err_len_d = err_len_q | (aligned_q && cnt_q == phase_len(state_q));
            end else if (state_q == PH_IDLE) begin
                // LEFT cannot start a sequence; anything else enters unaligned
                state_d   = (target_s == PH_LEFT) ? PH_IDLE : target_s;
                cnt_d     = LEN_W'(1);
                err_seq_d = err_seq_q | (target_s == PH_LEFT);
            end else begin
                state_d   = target_s;
                cnt_d     = LEN_W'(1);
                err_len_d = err_len_q | (aligned_q && cnt_q != phase_len(state_q));
                aligned_d = step_ok_s;
                err_seq_d = err_seq_q | !step_ok_s;
                if (step_ok_s && state_q == PH_RED) begin
                    done_d  = 1'b1;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end else begin
                    done_d  = 1'b0;
                end
            end
        end
    end

    // State and report registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PH_IDLE;
            cnt_q      <= {LEN_W{1'b0}};
            aligned_q  <= 1'b0;
            err_code_q <= 1'b0;
            err_seq_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_conf_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aligned_q  <= aligned_d;
            err_code_q <= err_code_d;
            err_seq_q  <= err_seq_d;
            err_len_q  <= err_len_d | walk_err_s;
            err_conf_q <= err_conf_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

`ifdef TRAFFIC_MON_WALKER_CHECK_EN
    typedef enum logic [1:0] {
        WS_PRE   = 2'd0,
        WS_GREEN = 2'd1,
        WS_BLINK = 2'd2,
        WS_POST  = 2'd3
    } wstage_e;

    wstage_e          wstage_q, wstage_d, wstage_cur_s;
    logic [LEN_W-1:0] wcnt_q, wcnt_d, wcnt_cur_s;
    logic [1:0]       wblink_exp_s;
    logic             wdev_s;

    // Walker pattern tracker during car RED; it restarts on every RED entry
    always_comb begin
        wstage_cur_s = (state_q == PH_RED) ? wstage_q : WS_PRE;
        wcnt_cur_s   = (state_q == PH_RED) ? wcnt_q : {LEN_W{1'b0}};
        wblink_exp_s = wcnt_cur_s[0] ? WLK_GREEN : WLK_NONE;
        wstage_d     = wstage_q;
        wcnt_d       = wcnt_q;
        wdev_s       = 1'b0;
        if (code_ok_s && mon.i_car_traffic == CAR_RED) begin
            wstage_d = wstage_cur_s;
            wcnt_d   = wcnt_cur_s;
            case (wstage_cur_s)
                WS_PRE: begin
                    if (mon.i_walker_traffic == WLK_GREEN) begin
                        wstage_d = WS_GREEN;
                        wcnt_d   = LEN_W'(1);
                    end else begin
                        wdev_s = (mon.i_walker_traffic != WLK_RED);
                    end
                end
                WS_GREEN: begin
                    if (mon.i_walker_traffic == WLK_GREEN && wcnt_cur_s < LEN_W'(WGREEN_LEN)) begin
                        wcnt_d = wcnt_cur_s + LEN_W'(1);
                    end else if (mon.i_walker_traffic == WLK_NONE && wcnt_cur_s == LEN_W'(WGREEN_LEN)) begin
                        wstage_d = WS_BLINK;
                        wcnt_d   = LEN_W'(1);
                    end else begin
                        wdev_s = 1'b1;
                    end
                end
                WS_BLINK: begin
                    if (wcnt_cur_s == LEN_W'(BLINK_LEN)) begin
                        wstage_d = WS_POST;
                        wdev_s   = (mon.i_walker_traffic != WLK_RED);
                    end else if (mon.i_walker_traffic == wblink_exp_s) begin
                        wcnt_d = wcnt_cur_s + LEN_W'(1);
                    end else begin
                        wdev_s = 1'b1;
                    end
                end
                WS_POST:  wdev_s   = (mon.i_walker_traffic != WLK_RED);
                default:  wstage_d = WS_PRE;
            endcase
        end else if (code_ok_s && !car_none_s && state_q == PH_RED) begin
            wdev_s = (wstage_q != WS_POST);
        end else begin
            wdev_s = 1'b0;
        end
    end

    // Walker tracker registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstage_q <= WS_PRE;
            wcnt_q   <= {LEN_W{1'b0}};
        end else if (mon.i_clear) begin
            wstage_q <= WS_PRE;
            wcnt_q   <= {LEN_W{1'b0}};
        end else begin
            wstage_q <= wstage_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign walk_err_s = aligned_q & wdev_s & ~mon.i_clear;
`else
    assign walk_err_s = 1'b0;
`endif

    assign mon.o_phase        = state_q;
    assign mon.o_err_code     = err_code_q;
    assign mon.o_err_seq      = err_seq_q;
    assign mon.o_err_len      = err_len_q;
    assign mon.o_err_conflict = err_conf_q;
    assign mon.o_cycle_done   = done_q;
    assign mon.o_cycle_count  = count_q;
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed plus randomized stimulus checked against a per-sample reference model.
module tb_traffic_monitor;
    localparam int GREEN_LEN  = 20;
    localparam int YELLOW_LEN = 2;
    localparam int LEFT_LEN   = 10;
    localparam int RED_LEN    = 34;

    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_GREEN = 2'b01;
    localparam logic [1:0] W_RED   = 2'b10;

    logic clk = 1'b0;
    logic reset;
    traffic_monitor_if mon_if();

    traffic_monitor dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_done_seen = 0;

    // reference model: phase index 0..5, samples seen in the current phase
    int m_ph, m_run, m_count;
    bit m_al, m_code, m_seq, m_len, m_conf, m_done;
    int         exp_len[6] = '{0, GREEN_LEN, YELLOW_LEN, LEFT_LEN, YELLOW_LEN, RED_LEN};
    int         succ[6]    = '{-1, 2, 3, 4, 5, 1};
    logic [3:0] code_of[6] = '{4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0100, 4'b1000};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_run = 0; m_count = 0;
        m_al = 0; m_code = 0; m_seq = 0; m_len = 0; m_conf = 0; m_done = 0;
    endtask

    task automatic model_step(input bit clr, input logic [3:0] car, input logic [1:0] wk);
        int  nph;
        bit  legal;
        m_done = 0;
        if (clr) begin
            model_reset();
            return;
        end
        legal = (car inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) && (wk != 2'b11)
                && !(car == 4'b0000 && wk != 2'b00);
        if ((car == 4'b0001 || car == 4'b0010 || car == 4'b0100) && wk != W_RED) m_conf = 1;
        if (!legal) begin
            m_code = 1;
            return;
        end
        if (car == 4'b0000) begin
            m_ph = 0; m_run = 1; m_al = 0;
            return;
        end
        case (car)
            4'b0001: nph = 1;
            4'b0010: nph = 3;
            4'b1000: nph = 5;
            default: nph = (m_ph == 1 || m_ph == 2) ? 2 : 4;
        endcase
        if (nph == m_ph) begin
            m_run++;
            if (m_al && m_run == exp_len[m_ph] + 1) m_len = 1;
        end else if (m_ph == 0) begin
            if (nph == 3) m_seq = 1;
            else begin
                m_ph = nph; m_run = 1;
            end
        end else begin
            if (m_al && m_run != exp_len[m_ph]) m_len = 1;
            if (nph == succ[m_ph]) begin
                m_al = 1;
                if (m_ph == 5) begin
                    m_done = 1;
                    if (m_count < 65535) m_count++;
                end
            end else begin
                m_seq = 1; m_al = 0;
            end
            m_ph = nph; m_run = 1;
        end
    endtask

    task automatic check_all();
        check_val("phase",    32'(mon_if.o_phase),        32'(m_ph));
        check_val("err_code", 32'(mon_if.o_err_code),     32'(m_code));
        check_val("err_seq",  32'(mon_if.o_err_seq),      32'(m_seq));
        check_val("err_len",  32'(mon_if.o_err_len),      32'(m_len));
        check_val("err_conf", 32'(mon_if.o_err_conflict), 32'(m_conf));
        check_val("done",     32'(mon_if.o_cycle_done),   32'(m_done));
        check_val("count",    32'(mon_if.o_cycle_count),  32'(m_count));
    endtask

    task automatic cycle(input bit clr, input logic [3:0] car, input logic [1:0] wk);
        mon_if.i_clear          = clr;
        mon_if.i_car_traffic    = car;
        mon_if.i_walker_traffic = wk;
        @(posedge clk);
        model_step(clr, car, wk);
        @(negedge clk);
        if (mon_if.o_cycle_done === 1'b1) n_done_seen++;
        check_all();
    endtask

    task automatic run_phase(input int ph, input int len, input logic [1:0] wk);
        for (int i = 0; i < len; i++) cycle(1'b0, code_of[ph], wk);
    endtask

    task automatic full_cycle();
        for (int p = 1; p <= 5; p++) run_phase(p, exp_len[p], W_RED);
    endtask

    task automatic do_clear();
        cycle(1'b1, 4'b0000, W_NONE);
    endtask

    initial begin
        int nxt;
        int len;
        int r;
        logic [1:0] wk;

        reset = 1'b1;
        mon_if.i_clear = 1'b0;
        mon_if.i_car_traffic = 4'b0000;
        mon_if.i_walker_traffic = W_NONE;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b0;

        // three legal cycles starting at GREEN
        for (int c = 0; c < 3; c++) full_cycle();
        run_phase(1, 5, W_RED);
        check_val("done_pulses", 32'(n_done_seen), 32'd3);
        check_val("cycles3", 32'(mon_if.o_cycle_count), 32'd3);
        check_val("clean3", 32'({mon_if.o_err_code, mon_if.o_err_seq, mon_if.o_err_len, mon_if.o_err_conflict}), 32'd0);
        cycle(1'b0, 4'b0000, W_NONE);
        check_val("none_idle", 32'(mon_if.o_phase), 32'd0);
        check_val("none_noerr", 32'({mon_if.o_err_code, mon_if.o_err_seq, mon_if.o_err_len}), 32'd0);

        // long first GREEN after IDLE is not a length error
        do_clear();
        run_phase(1, 21, W_RED);
        for (int p = 2; p <= 5; p++) run_phase(p, exp_len[p], W_RED);
        full_cycle();
        check_val("first_green_21", 32'(mon_if.o_err_len), 32'd0);

        // aligned LEFT held for 11 clocks
        do_clear();
        run_phase(1, GREEN_LEN, W_RED);
        run_phase(2, YELLOW_LEN, W_RED);
        run_phase(3, LEFT_LEN, W_RED);
        check_val("left10_len", 32'(mon_if.o_err_len), 32'd0);
        run_phase(3, 1, W_RED);
        check_val("left11_len", 32'(mon_if.o_err_len), 32'd1);
        run_phase(4, YELLOW_LEN, W_RED);
        run_phase(5, 3, W_RED);
        check_val("len_sticky", 32'(mon_if.o_err_len), 32'd1);
        do_clear();
        check_val("len_cleared", 32'(mon_if.o_err_len), 32'd0);

        // GREEN straight to LEFT
        run_phase(1, 5, W_RED);
        run_phase(3, 1, W_RED);
        check_val("g2l_seq", 32'(mon_if.o_err_seq), 32'd1);
        check_val("g2l_phase", 32'(mon_if.o_phase), 32'd3);

        // conflict, then an illegal car code
        do_clear();
        cycle(1'b0, 4'b0001, W_GREEN);
        check_val("conflict", 32'(mon_if.o_err_conflict), 32'd1);
        cycle(1'b0, 4'b0110, W_RED);
        check_val("bad_code", 32'(mon_if.o_err_code), 32'd1);
        check_val("bad_code_phase", 32'(mon_if.o_phase), 32'd1);

        // randomized mostly-legal traffic with glitches, drops and clears
        do_clear();
        nxt = 1;
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                cycle(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end else if (r == 1) begin
                repeat ($urandom_range(1, 3)) cycle(1'b0, 4'b0000, W_NONE);
            end else if (r == 2) begin
                cycle(1'b1, code_of[nxt], W_RED);
            end else begin
                len = exp_len[nxt];
                if ($urandom_range(0, 4) == 0) len = ($urandom_range(0, 1) == 1) ? len + 1 : len - 1;
                if (len < 1) len = 1;
                for (int i = 0; i < len; i++) begin
                    if (nxt == 5) wk = 2'($urandom_range(0, 2));
                    else wk = ($urandom_range(0, 39) == 0) ? W_GREEN : W_RED;
                    cycle(1'b0, code_of[nxt], wk);
                end
                nxt = (nxt == 5) ? 1 : nxt + 1;
                if ($urandom_range(0, 15) == 0) nxt = int'($urandom_range(1, 5));
            end
        end

        // asynchronous reset in the middle of RED
        do_clear();
        full_cycle();
        run_phase(1, GREEN_LEN, W_RED);
        run_phase(2, YELLOW_LEN, W_RED);
        run_phase(3, LEFT_LEN, W_RED);
        run_phase(4, YELLOW_LEN, W_RED);
        run_phase(5, 10, W_RED);
        check_val("pre_reset_count", 32'(mon_if.o_cycle_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("rst_phase", 32'(mon_if.o_phase), 32'd0);
        check_val("rst_count", 32'(mon_if.o_cycle_count), 32'd0);
        check_val("rst_flags", 32'({mon_if.o_err_code, mon_if.o_err_seq, mon_if.o_err_len,
                                    mon_if.o_err_conflict, mon_if.o_cycle_done}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_phase(5, 4, W_RED);
        run_phase(1, 3, W_RED);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
- Passive receiver/checker on the car/walker light bus driven by the traffic controller.
- Decodes the one-hot light codes into a phase and tracks the car phase FSM.
- Checks code legality, phase order, phase durations and car/walker conflicts.
- Reports sticky error flags plus a completed-cycle counter; sits beside the controller in the top level and in benches.

Parameters:
- GREEN_LEN, 20, steady-state car GREEN length in clocks
- YELLOW_LEN, 2, length of each car YELLOW phase
- LEFT_LEN, 10, car LEFT length
- RED_LEN, 34, car RED length
- WGREEN_LEN, 14, walker solid-GREEN length (optional feature only)
- BLINK_LEN, 6, walker blink window length (optional feature only)
- LEN_W, 8, width of the phase-length counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- i_clear  in  1  synchronous clear of sticky errors, cycle count and FSM (to IDLE)
- i_car_traffic  in  4  car code: 1000 RED, 0100 YELLOW, 0010 LEFT, 0001 GREEN, 0000 NONE
- i_walker_traffic  in  2  walker code: 10 RED, 01 GREEN, 00 NONE
- o_phase  out  3  0 IDLE, 1 GREEN, 2 YELLOW_A, 3 LEFT, 4 YELLOW_B, 5 RED
- o_err_code  out  1  sticky: illegal code seen
- o_err_seq  out  1  sticky: illegal phase transition
- o_err_len  out  1  sticky: phase length mismatch
- o_err_conflict  out  1  sticky: walker not RED while car not RED
- o_cycle_done  out  1  one-clock pulse on each completed RED->GREEN wrap
- o_cycle_count  out  16  completed cycles, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high) or i_clear: FSM IDLE, counter 0, aligned flag 0, all outputs 0. i_clear takes priority over other updates.
- Inputs are sampled every rising edge. Flags and o_phase update on that same edge (1-clock latency from input to output).
- Illegal codes: a car code not in the 5 legal values, walker 11, or car NONE with walker not NONE. Sets o_err_code. FSM and counter hold; the phase is not updated.
- FSM transitions on car code:
  - IDLE: GREEN->GREEN; YELLOW->YELLOW_B; RED->RED; LEFT->err_seq and stay IDLE.
  - Legal order: GREEN->YELLOW_A->LEFT->YELLOW_B->RED->GREEN.
  - Car NONE from any state returns to IDLE, clears the aligned flag, and is never an error.
  - Any other change sets o_err_seq. The FSM follows the decoded code; YELLOW goes to YELLOW_A if coming from GREEN, otherwise YELLOW_B. The aligned flag is cleared.
- Length counter:
  - Loads 1 on phase entry and increments each clock the phase holds. It saturates at all-ones.
- Length check:
  - Applies only when the aligned flag is set.
  - The aligned flag sets on the first legal transition after IDLE, because the first phase after start may be truncated or extended.
  - On leaving a phase, counter != expected length sets o_err_len.
  - While holding a phase, counter reaching expected length with the same code still present on the next sample sets o_err_len once per phase.
- Conflict: car phase GREEN/YELLOW_A/LEFT/YELLOW_B with walker != RED sets o_err_conflict.
- Cycle count: each legal RED->GREEN transition pulses o_cycle_done for 1 clock and increments o_cycle_count, regardless of the aligned flag.
- All error flags are sticky until reset or i_clear. Simultaneous errors set all of the relevant flags in the same clock.

Optional Feature:
- Macro TRAFFIC_MON_WALKER_CHECK_EN.
- Defined: during car RED, the walker sequence is checked:
  - First 0 or more clocks RED, then WGREEN_LEN clocks GREEN.
  - Then BLINK_LEN clocks alternating NONE/GREEN, starting NONE.
  - Then RED until car GREEN.
  - A deviation in an aligned cycle sets o_err_len.
- Undefined: walker is checked only for code legality and conflict; the walker counter logic is absent.

Test Plan:
- Start at GREEN, run 3 full legal cycles (20/2/10/2/34) -> phases 1,2,3,4,5 in order, 3 o_cycle_done pulses, o_cycle_count=3, all errors 0.
- First GREEN lasts 21 clocks after IDLE, then legal cycles -> o_err_len stays 0.
- Aligned cycle with LEFT 11 clocks -> o_err_len=1 one clock after the 11th LEFT sample; it holds until i_clear, then returns to 0.
- GREEN->LEFT directly -> o_err_seq=1, o_phase=3.
- Car GREEN with walker GREEN -> o_err_conflict=1 next clock. Car 0110 -> o_err_code=1, o_phase unchanged.
- Assert reset mid-RED -> all outputs 0 immediately. Car NONE mid-cycle -> o_phase=0 with no error.
